axi_route_decoder: RTL

Parametrised AXI address decoder with ordering lock, one instance per master address channel (AR or AW) inside the AXI interconnect. It maps the address upper field onto NUM_SLAVES regions plus one default slave. It forwards VALID/READY for the selected slave with zero latency. It tracks outstanding transactions so a master cannot issue to a different slave until all earlier responses have returned. It also exports the locked slave to steer the response-channel mux.

---
 rtl/axi_route_decoder.sv | 106 ++++++++++
 1 files changed

// File: rtl/axi_route_decoder.sv
// Address decoder with ordering lock: maps addr upper field onto NUM_SLAVES regions plus a default slave.
// Latency: address/valid/ready path is zero-cycle combinational; the count, lock and error state update one edge later.
// Backpressure: ready_o mirrors the selected slave's ready; a request to another slave, or any request once full, stalls with valid_s_o=0.
module axi_route_decoder #(
    parameter int NUM_SLAVES      = 2,
    parameter int ADDR_BITS       = 32,
    parameter int SEL_MSB         = 31,
    parameter int SEL_LSB         = 16,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1),
    localparam int NS             = NUM_SLAVES + 1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [NS-1:0]        valid_s_o,
    input  logic [NS-1:0]        ready_s_i,
    input  logic                 resp_done_i,
    output logic [NS-1:0]        resp_sel_o,
    output logic [CW-1:0]        outstanding_o,
    output logic                 err_o
);

    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam int SW = SEL_MSB - SEL_LSB + 1;
    localparam logic [SW-1:0] SEL_NUM = SW'(NUM_SLAVES);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [SW-1:0] field;
    logic [IW-1:0] tgt;
    logic [IW-1:0] lock_sel;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          issue_ok;
    logic          hs;
    logic          unused_addr;

    // Only the select field steers routing; remaining address bits travel with the request untouched.
    assign unused_addr = ^addr_i;

    // Region decode: out-of-range field values fall through to the default slave.
    always_comb begin
        field = addr_i[SEL_MSB:SEL_LSB];
        tgt   = IW'(NUM_SLAVES);
        if (field < SEL_NUM) begin
            tgt = IW'(field);
        end
    end

    // Issue gating uses registered state only, so resp_done_i never reaches the address path.
    always_comb begin
        issue_ok  = valid_i && !ARESET &&
                    ((cnt == '0) || ((tgt == lock_sel) && (cnt < MAX_CNT)));
        valid_s_o = '0;
        ready_o   = 1'b0;
        if (issue_ok) begin
            valid_s_o = NS'(1) << tgt;
            ready_o   = ready_s_i[tgt];
        end
        hs = ready_o;
    end

    // Outstanding count: accept and retire in the same cycle cancel; a stray retire never underflows.
    always_comb begin
        cnt_nxt = cnt;
        if (hs && !resp_done_i) begin
            cnt_nxt = cnt + CW'(1);
        end else if (!hs && resp_done_i && (cnt != '0)) begin
            cnt_nxt = cnt - CW'(1);
        end else if (hs && resp_done_i && (cnt == '0)) begin
            cnt_nxt = CW'(1);
        end
    end

    // State register: count, locked slave and sticky protocol error.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt      <= '0;
            lock_sel <= '0;
            err_o    <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (hs) begin
                lock_sel <= tgt;
            end
            if (resp_done_i && (cnt == '0)) begin
                err_o <= 1'b1;
            end
        end
    end

    // Response steering and count are forced quiet while reset is held.
    always_comb begin
        resp_sel_o    = '0;
        outstanding_o = '0;
        if (!ARESET) begin
            outstanding_o = cnt;
            if (cnt != '0) begin
                resp_sel_o = NS'(1) << lock_sel;
            end
        end
    end

endmodule
